// File: rtl/router_fsm.sv
// router_fsm: 1x3 router control FSM (address decode, header/payload/parity sequencing).
module router_fsm #(parameter int WDOG_CYCLES = 255) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       wdog_err
);
  typedef enum logic [2:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE} state_e;
  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] empty_w, srst_w;
  logic       addr_ok, srst, timeout;
  assign empty_w = {1'b0, fifo_empty};
  assign srst_w  = {1'b0, soft_reset};
  assign addr_ok = pkt_valid && data_in != 2'b11;
  assign srst    = srst_w[addr_q] && state_q != DA;
`ifdef FSM_WDOG_EN
  logic [15:0] cnt_q;
  logic        stall;
  assign stall   = state_q == WTE || state_q == FFS;
  assign timeout = stall && cnt_q == 16'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt_q    <= '0;
      wdog_err <= 1'b0;
    end else begin
      cnt_q    <= (stall && !timeout && !srst) ? cnt_q + 16'd1 : '0;
      wdog_err <= timeout && !srst;
    end
`else
  assign timeout  = 1'b0;
  assign wdog_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DA:  if (addr_ok) begin
             addr_d  = data_in;
             state_d = empty_w[data_in] ? LFD : WTE;
           end
      LFD: state_d = LD;
      LD:  state_d = fifo_full ? FFS : !pkt_valid ? LP : LD;
      FFS: state_d = fifo_full ? FFS : LAF;
      LAF: state_d = parity_done ? DA : low_pkt_valid ? LP : LD;
      LP:  state_d = CPE;
      CPE: state_d = fifo_full ? FFS : DA;
      WTE: state_d = empty_w[addr_q] ? LFD : WTE;
    endcase
    if (srst || timeout) state_d = DA;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q       <= DA;
      addr_q        <= 2'b00;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
      write_enb_reg <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      detect_add    <= state_d == DA;
      lfd_state     <= state_d == LFD;
      ld_state      <= state_d == LD;
      laf_state     <= state_d == LAF;
      full_state    <= state_d == FFS;
      rst_int_reg   <= state_d == CPE;
      busy          <= state_d inside {LFD, FFS, LAF, LP, CPE, WTE};
      write_enb_reg <= state_d inside {LFD, LD, LAF, LP};
    end
endmodule
